// File: rtl/kmc_pkg.sv
// Shared scancode constants, decoder state type, key bit indices and the
// per-axis step/clamp helper for key_motion_ctrl.
package kmc_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [1:0] KEY_UP    = 2'd0;
  localparam logic [1:0] KEY_DOWN  = 2'd1;
  localparam logic [1:0] KEY_LEFT  = 2'd2;
  localparam logic [1:0] KEY_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BREAK,
    ST_EXT,
    ST_EXT_BREAK
  } dec_state_t;

  typedef enum logic [1:0] {
    MV_NONE,
    MV_DEC,
    MV_INC
  } move_dir_t;

  // Opposing keys cancel; only a lone key produces movement.
  function automatic move_dir_t axis_dir(input logic dec_key, input logic inc_key);
    if (dec_key && !inc_key) return MV_DEC;
    if (inc_key && !dec_key) return MV_INC;
    return MV_NONE;
  endfunction

  function automatic logic [9:0] step_clamp(input logic [9:0]  cur,
                                            input move_dir_t   dir,
                                            input logic [10:0] step,
                                            input logic [10:0] limit);
    logic [10:0] wide;
    logic [10:0] res;
    wide = {1'b0, cur};
    res  = wide;
    case (dir)
      MV_DEC: begin
        res = (wide < step) ? 11'd0 : wide - step;
        if (res > limit) res = limit;
      end
      MV_INC: begin
        res = wide + step;
        if (res > limit) res = limit;
      end
      default: res = wide;
    endcase
    return res[9:0];
  endfunction

endpackage

// File: rtl/kmc_scancode_decoder.sv
// PS/2 set-2 scancode decoder: emits a one-cycle make/break event with a key index.
// Arrow keys (E0-prefixed) are decoded only when KMC_ARROW_KEYS_EN is defined.
module kmc_scancode_decoder
  import kmc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       key_evt,
  output logic       key_make,
  output logic [1:0] key_idx
);

  dec_state_t state;
  logic       mapped;

  // Events are combinational so the held-key register updates the cycle after the byte.
  always_comb begin
    mapped  = 1'b0;
    key_idx = KEY_UP;
    if (state == ST_IDLE || state == ST_BREAK) begin
      case (rx_data)
        SC_W:    begin mapped = 1'b1; key_idx = KEY_UP;    end
        SC_S:    begin mapped = 1'b1; key_idx = KEY_DOWN;  end
        SC_A:    begin mapped = 1'b1; key_idx = KEY_LEFT;  end
        SC_D:    begin mapped = 1'b1; key_idx = KEY_RIGHT; end
        default: mapped = 1'b0;
      endcase
    end else begin
`ifdef KMC_ARROW_KEYS_EN
      case (rx_data)
        SC_UP:    begin mapped = 1'b1; key_idx = KEY_UP;    end
        SC_DOWN:  begin mapped = 1'b1; key_idx = KEY_DOWN;  end
        SC_LEFT:  begin mapped = 1'b1; key_idx = KEY_LEFT;  end
        SC_RIGHT: begin mapped = 1'b1; key_idx = KEY_RIGHT; end
        default:  mapped = 1'b0;
      endcase
`else
      mapped = 1'b0;
`endif
    end
    key_evt  = rx_done_tick && mapped;
    key_make = (state == ST_IDLE) || (state == ST_EXT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else if (rx_done_tick) begin
      case (state)
        ST_IDLE: begin
          if (rx_data == SC_BREAK)    state <= ST_BREAK;
          else if (rx_data == SC_EXT) state <= ST_EXT;
          else                        state <= ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data == SC_BREAK) state <= ST_EXT_BREAK;
          else                     state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_motion_ctrl.sv
// Keyboard-driven motion of two sprites: held-key tracking plus per-frame clamped steps.
// Optional arrow-key support is enabled with the KMC_ARROW_KEYS_EN macro.
module key_motion_ctrl
  import kmc_pkg::*;
#(
  parameter int STEP        = 4,
  parameter int SPRITE_SIZE = 51,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int X0_INIT     = 0,
  parameter int Y0_INIT     = 0,
  parameter int X1_INIT     = 100,
  parameter int Y1_INIT     = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  input  logic       frame_tick,
  output logic [9:0] x0,
  output logic [9:0] y0,
  output logic [9:0] x1,
  output logic [9:0] y1,
  output logic [3:0] keys_held,
  output logic       move_valid
);

  localparam logic [10:0] STEP_W  = 11'(STEP);
  localparam logic [10:0] X_LIMIT = 11'(SCREEN_W - SPRITE_SIZE);
  localparam logic [10:0] Y_LIMIT = 11'(SCREEN_H - SPRITE_SIZE);

  logic       key_evt;
  logic       key_make;
  logic [1:0] key_idx;

  kmc_scancode_decoder u_decoder (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .key_evt      (key_evt),
    .key_make     (key_make),
    .key_idx      (key_idx)
  );

  move_dir_t  x_dir;
  move_dir_t  y_dir;
  logic [9:0] x0_next;
  logic [9:0] y0_next;
  logic [9:0] x1_next;
  logic [9:0] y1_next;
  logic       any_change;

  // Movement reads the registered keys, so a byte landing with frame_tick affects the next frame.
  always_comb begin
    x_dir      = axis_dir(keys_held[KEY_LEFT], keys_held[KEY_RIGHT]);
    y_dir      = axis_dir(keys_held[KEY_UP], keys_held[KEY_DOWN]);
    x0_next    = step_clamp(x0, x_dir, STEP_W, X_LIMIT);
    y0_next    = step_clamp(y0, y_dir, STEP_W, Y_LIMIT);
    x1_next    = step_clamp(x1, x_dir, STEP_W, X_LIMIT);
    y1_next    = step_clamp(y1, y_dir, STEP_W, Y_LIMIT);
    any_change = (x0_next != x0) || (y0_next != y0) ||
                 (x1_next != x1) || (y1_next != y1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x0         <= 10'(X0_INIT);
      y0         <= 10'(Y0_INIT);
      x1         <= 10'(X1_INIT);
      y1         <= 10'(Y1_INIT);
      keys_held  <= 4'b0000;
      move_valid <= 1'b0;
    end else begin
      move_valid <= 1'b0;
      if (key_evt) keys_held[key_idx] <= key_make;
      if (frame_tick) begin
        x0         <= x0_next;
        y0         <= y0_next;
        x1         <= x1_next;
        y1         <= y1_next;
        move_valid <= any_change;
      end
    end
  end

endmodule
